led_frame_scheduler: RTL and testbench

// Sequences the read port of the LED colour buffer and feeds one 24-bit GRB word per LED to the WS2812 bit driver, then enforces the latch gap.

---
 rtl/led_frame_scheduler_pkg.sv | 25 ++
 rtl/led_frame_scheduler_if.sv | 37 +++
 rtl/led_frame_scheduler.sv | 151 +++++++++++++++
 tb/tb_led_frame_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_scheduler_pkg.sv
// Shared types and helpers for the LED frame scheduler.
package led_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    PRESENT,
    LATCH
  } sched_state_t;

  // WS2812 reset/latch low-time in microseconds.
  localparam int unsigned WS2812_LATCH_US = 50;

  // Scale each channel of an {R,G,B} word and reorder to the {G,R,B} wire order.
  function automatic logic [23:0] pack_grb(input logic [23:0] color, input int unsigned shift);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = color[23:16] >> shift;
    g = color[15:8] >> shift;
    b = color[7:0] >> shift;
    return {g, r, b};
  endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Colour buffer read port plus WS2812 bit-driver word handshake.
interface led_frame_scheduler_if #(
  parameter int unsigned LED_ADDRESS_WIDTH = 6,
  parameter int unsigned COLOR_WIDTH       = 24
);

  logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address;
  logic [COLOR_WIDTH-1:0]       buf_data;
  logic                         buf_color_valid;
  logic [23:0]                  drv_color;
  logic                         drv_valid;
  logic                         drv_ready;
  logic                         drv_latch;

  // Scheduler side.
  modport master (
    output next_led_request_address,
    input  buf_data,
    input  buf_color_valid,
    output drv_color,
    output drv_valid,
    input  drv_ready,
    output drv_latch
  );

  // Buffer / driver side.
  modport slave (
    input  next_led_request_address,
    output buf_data,
    output buf_color_valid,
    input  drv_color,
    input  drv_valid,
    output drv_ready,
    input  drv_latch
  );

endinterface

// File: rtl/led_frame_scheduler.sv
// Walks the colour buffer once per frame, hands one scaled GRB word per LED to the
// bit driver, then holds the line in latch for the reset gap.
module led_frame_scheduler
  import led_frame_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LEDS          = 50,
  parameter int unsigned LED_ADDRESS_WIDTH = $clog2(NUM_LEDS),
  parameter int unsigned COLOR_WIDTH       = 24,
  parameter int unsigned BRIGHT_SHIFT      = 4,
  parameter int unsigned SETTLE_CYCLES     = 2,
  parameter int unsigned VALID_TIMEOUT     = 16,
  // Default assumes a 100 MHz LED clock.
  parameter int unsigned LATCH_CYCLES      = WS2812_LATCH_US * 100
) (
  input  logic                         clk_led,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         buffer_wiping,
  led_frame_scheduler_if.master        bus,
  output logic                         frame_done,
  output logic                         busy,
  output logic [7:0]                   timeout_count
);

  localparam int unsigned TIMER_MAX =
      (LATCH_CYCLES > VALID_TIMEOUT) ? LATCH_CYCLES : VALID_TIMEOUT;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int unsigned SETTLE_W  = $clog2(SETTLE_CYCLES + 2);

  localparam logic [TIMER_W-1:0]           TimeoutLoad = TIMER_W'(VALID_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]           LatchLoad   = TIMER_W'(LATCH_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]          SettleLoad  = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [LED_ADDRESS_WIDTH-1:0] LastLed     = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);

  sched_state_t                 state_q, state_d;
  logic [LED_ADDRESS_WIDTH-1:0] index_q, index_d;
  logic [SETTLE_W-1:0]          settle_q, settle_d;
  // Shared down-counter: valid timeout in REQUEST, latch gap in LATCH.
  logic [TIMER_W-1:0]           timer_q, timer_d;
  logic [23:0]                  color_q, color_d;
  logic [7:0]                   tmo_cnt_q, tmo_cnt_d;
  logic                         frame_done_q, frame_done_d;
  logic [COLOR_WIDTH-1:0]       buf_word;

  assign buf_word = bus.buf_data;

  // Next-state, counter and capture logic.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    settle_d     = settle_q;
    timer_d      = timer_q;
    color_d      = color_q;
    tmo_cnt_d    = tmo_cnt_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        index_d  = '0;
        settle_d = SettleLoad;
        timer_d  = TimeoutLoad;
        if (enable && !buffer_wiping) begin
          state_d = REQUEST;
        end
      end

      REQUEST: begin
        if (buffer_wiping) begin
          // Timeout frozen; settling starts over once the wipe ends.
          settle_d = SettleLoad;
        end else begin
          if (settle_q == '0 && bus.buf_color_valid) begin
            color_d = pack_grb(buf_word[23:0], BRIGHT_SHIFT);
            state_d = PRESENT;
          end else if (timer_q == '0) begin
            color_d = '0;
            state_d = PRESENT;
            if (tmo_cnt_q != 8'hFF) begin
              tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
          if (settle_q != '0) begin
            settle_d = settle_q - SETTLE_W'(1);
          end
        end
      end

      PRESENT: begin
        if (bus.drv_ready) begin
          if (index_q == LastLed) begin
            index_d = '0;
            timer_d = LatchLoad;
            state_d = LATCH;
          end else begin
            index_d  = index_q + LED_ADDRESS_WIDTH'(1);
            settle_d = SettleLoad;
            timer_d  = TimeoutLoad;
            state_d  = REQUEST;
          end
        end
      end

      LATCH: begin
        if (timer_q == '0) begin
          frame_done_d = 1'b1;
          settle_d     = SettleLoad;
          timer_d      = TimeoutLoad;
          state_d      = (enable && !buffer_wiping) ? REQUEST : IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_led or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      settle_q     <= '0;
      timer_q      <= '0;
      color_q      <= '0;
      tmo_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      settle_q     <= settle_d;
      timer_q      <= timer_d;
      color_q      <= color_d;
      tmo_cnt_q    <= tmo_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.next_led_request_address = index_q;
  assign bus.drv_color                = color_q;
  assign bus.drv_valid                = (state_q == PRESENT);
  assign bus.drv_latch                = (state_q == LATCH);
  assign frame_done                   = frame_done_q;
  assign busy                         = (state_q != IDLE);
  assign timeout_count                = tmo_cnt_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: four frames covering colour scaling, settle
// masking, valid timeout, driver back-pressure, enable drop, buffer wipe and reset.
module tb_led_frame_scheduler;

  logic       clk_led;
  logic       rst;
  logic       enable;
  logic       buffer_wiping;
  logic       frame_done;
  logic       busy;
  logic [7:0] timeout_count;

  int n_assert;
  int n_fail;

  // Buffer model controls.
  bit          data_mode;  // 0: constant word, 1: address-dependent word, two-cycle read latency
  bit          valid_en;
  int          bad_addr;   // address for which valid never asserts
  logic [23:0] pipe1;
  logic [23:0] pipe2;

  led_frame_scheduler_if #(.LED_ADDRESS_WIDTH(6), .COLOR_WIDTH(24)) bus ();

  led_frame_scheduler dut (
    .clk_led       (clk_led),
    .rst           (rst),
    .enable        (enable),
    .buffer_wiping (buffer_wiping),
    .bus           (bus),
    .frame_done    (frame_done),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  initial clk_led = 1'b0;
  always #5 clk_led = ~clk_led;

  // Buffer word for address a: R = a<<4 (truncated), G = FF, B = 37.
  function automatic logic [23:0] buf_word(input logic [5:0] a);
    return {a[3:0], 4'h0, 8'hFF, 8'h37};
  endfunction

  // Hand-derived scaled GRB for buf_word(a): G'=0F, R'=a[3:0], B'=03.
  function automatic logic [23:0] exp_word(input int a);
    logic [3:0] lo;
    lo = a[3:0];
    return {8'h0F, 4'h0, lo, 8'h03};
  endfunction

  // Read data lags the address by two clocks while valid is held high.
  always @(posedge clk_led) begin
    pipe1 <= buf_word(bus.next_led_request_address);
    pipe2 <= pipe1;
  end

  assign bus.buf_data        = data_mode ? pipe2 : 24'hF08010;
  assign bus.buf_color_valid = valid_en && (int'(bus.next_led_request_address) != bad_addr);

  task automatic tick();
    @(posedge clk_led);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance at least one clock, then until drv_valid, bounded by budget.
  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.drv_valid && lat < budget);
    if (!bus.drv_valid) chk("valid_wait_expired", {31'd0, bus.drv_valid}, 32'd1);
  endtask

  // Called after the last LED is seen; measures the latch gap and the done pulse.
  task automatic run_latch(input string tag);
    int n;
    n = 0;
    tick();
    while (bus.drv_latch && n < 6000) begin
      n++;
      tick();
    end
    chk({tag, "_latch_len"}, n, 32'd5000);
    chk({tag, "_done_hi"}, {31'd0, frame_done}, 32'd1);
    tick();
    chk({tag, "_done_lo"}, {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    int  lat;
    bit  saw_valid;
    logic [23:0] held;

    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    enable        = 1'b0;
    buffer_wiping = 1'b0;
    bus.drv_ready = 1'b1;
    data_mode     = 1'b0;
    valid_en      = 1'b1;
    bad_addr      = 99;

    // Reset state.
    repeat (3) tick();
    chk("rst_valid", {31'd0, bus.drv_valid}, 32'd0);
    chk("rst_latch", {31'd0, bus.drv_latch}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_tmo", {24'd0, timeout_count}, 32'd0);
    chk("rst_addr", {26'd0, bus.next_led_request_address}, 32'd0);
    chk("rst_color", {8'd0, bus.drv_color}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Frame 1: constant F0/80/10 word scales to 080F01 on every LED.
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      wait_valid(40, lat);
      chk("f1_addr", {26'd0, bus.next_led_request_address}, i);
      chk("f1_color", {8'd0, bus.drv_color}, 32'h080F01);
    end
    data_mode = 1'b1;
    run_latch("f1");

    // Frame 2: stale-data masking, LED 7 timeout, back-pressure on LED 10.
    bad_addr = 7;
    for (int i = 0; i < 50; i++) begin
      wait_valid(40, lat);
      chk("f2_addr", {26'd0, bus.next_led_request_address}, i);
      chk("f2_color", {8'd0, bus.drv_color}, (i == 7) ? 32'd0 : {8'd0, exp_word(i)});
      if (i == 3) chk("f2_lat_normal", lat, 32'd4);
      if (i == 7) begin
        chk("f2_lat_timeout", lat, 32'd17);
        chk("f2_tmo_count", {24'd0, timeout_count}, 32'd1);
      end
      if (i == 8) chk("f2_lat_after_tmo", lat, 32'd4);
      if (i == 9) begin
        tick();
        bus.drv_ready = 1'b0;
      end
      if (i == 10) begin
        held = bus.drv_color;
        for (int k = 0; k < 10; k++) begin
          tick();
          chk("f2_stall_valid", {31'd0, bus.drv_valid}, 32'd1);
          chk("f2_stall_color", {8'd0, bus.drv_color}, {8'd0, held});
          chk("f2_stall_addr", {26'd0, bus.next_led_request_address}, 32'd10);
        end
        bus.drv_ready = 1'b1;
        tick();
        chk("f2_xfer_valid", {31'd0, bus.drv_valid}, 32'd0);
        chk("f2_xfer_addr", {26'd0, bus.next_led_request_address}, 32'd11);
      end
    end
    bad_addr = 99;
    run_latch("f2");

    // Frame 3: enable dropped after LED 20; frame still completes, then IDLE.
    for (int i = 0; i < 50; i++) begin
      wait_valid(40, lat);
      chk("f3_addr", {26'd0, bus.next_led_request_address}, i);
      chk("f3_color", {8'd0, bus.drv_color}, {8'd0, exp_word(i)});
      if (i == 20) enable = 1'b0;
    end
    run_latch("f3");
    chk("f3_idle_busy", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    chk("f3_idle_busy2", {31'd0, busy}, 32'd0);
    chk("f3_idle_valid", {31'd0, bus.drv_valid}, 32'd0);
    chk("f3_idle_addr", {26'd0, bus.next_led_request_address}, 32'd0);
    chk("f3_tmo_kept", {24'd0, timeout_count}, 32'd1);

    // Frame 4: buffer wipe for 60 cycles in REQUEST, valid held high throughout.
    enable = 1'b1;
    tick();
    chk("f4_busy", {31'd0, busy}, 32'd1);
    buffer_wiping = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus.drv_valid) saw_valid = 1'b1;
    end
    chk("f4_no_capture", {31'd0, saw_valid}, 32'd0);
    buffer_wiping = 1'b0;
    wait_valid(40, lat);
    chk("f4_settle_lat", lat, 32'd3);
    chk("f4_color", {8'd0, bus.drv_color}, {8'd0, exp_word(0)});
    chk("f4_tmo_kept", {24'd0, timeout_count}, 32'd1);
    wait_valid(40, lat);
    chk("f4_led1_addr", {26'd0, bus.next_led_request_address}, 32'd1);

    // Asynchronous reset mid-frame.
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, bus.drv_valid}, 32'd0);
    chk("arst_addr", {26'd0, bus.next_led_request_address}, 32'd0);
    chk("arst_tmo", {24'd0, timeout_count}, 32'd0);
    chk("arst_color", {8'd0, bus.drv_color}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
